ibex_wb_arbiter: RTL and testbench
==================================

Name: ibex_wb_arbiter

Overview:
- Shares one pipelined Wishbone B4 master port between the Ibex instruction port and the Ibex data port (req/gnt/rvalid protocol).
- Sits between ibex_core and the system Wishbone interconnect, so a single-bus SoC needs only one master.
- Tracks outstanding transactions in order and routes each ack back to the port that issued the request.

Parameters:
- MaxOutstanding, 2, max accepted-but-unacked Wishbone transactions (1..4).
- DataFirst, 1, 1 = fixed priority to data port; 0 = round-robin.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- instr_req  in  1  instruction request
- instr_gnt  out  1  instruction request accepted
- instr_rvalid  out  1  instruction response valid
- instr_addr  in  32  instruction word address
- instr_rdata  out  32  instruction read data
- instr_err  out  1  instruction bus error
- data_req  in  1  data request
- data_gnt  out  1  data request accepted
- data_rvalid  out  1  data response valid (reads and writes)
- data_we  in  1  data write enable
- data_be  in  4  data byte enables
- data_addr  in  32  data word address
- data_wdata  in  32  data write data
- data_rdata  out  32  data read data
- data_err  out  1  data bus error
- wb_cyc  out  1  Wishbone cycle
- wb_stb  out  1  Wishbone strobe
- wb_we  out  1  Wishbone write enable
- wb_adr  out  32  Wishbone address
- wb_sel  out  4  Wishbone byte select
- wb_dat_o  out  32  Wishbone write data
- wb_dat_i  in  32  Wishbone read data
- wb_ack  in  1  Wishbone acknowledge
- wb_stall  in  1  Wishbone stall
- wb_err  in  1  Wishbone error

Behaviour:
- State: sel_q (owner of a stalled strobe), lock_q, last_q (last granted source), ID FIFO of MaxOutstanding entries, count.
- Reset: while rst_n low, all outputs are 0, FIFO empty, lock_q = 0, last_q = INSTR. Clearing is synchronous; wb_cyc/wb_stb are also gated combinationally by rst_n. In-flight acks after reset are ignored.
- Arbitration when lock_q = 0:
  - Only one req high: select it.
  - Both high, DataFirst = 1: select DATA.
  - Both high, DataFirst = 0: select the source != last_q.
- Arbitration when lock_q = 1: selection is sel_q regardless of the other req, so strobe and address stay stable under stall.
- Issue (combinational):
  - wb_stb = selected req & (count < MaxOutstanding).
  - wb_adr, wb_sel, wb_we, wb_dat_o come from the selected port.
  - For the instruction source: sel = 4'hF, we = 0, dat_o = 0.
- Accept: wb_stb & ~wb_stall. The selected gnt is high in the same cycle, push the source ID, last_q <= source, lock_q <= 0.
- Stall: wb_stb & wb_stall sets lock_q <= 1 and sel_q <= source. No gnt while stalled.
- Full (count == MaxOutstanding): wb_stb = 0, both gnt = 0, lock is held.
- Response:
  - wb_ack | wb_err with count > 0 pops the FIFO head.
  - <head>_rvalid = 1 for one cycle; rdata = wb_dat_i on both rdata ports.
  - Ack with count == 0 is ignored.
- Push and pop in the same cycle leave count unchanged and are legal when full, but a new accept needs count < MaxOutstanding at cycle start.
- wb_cyc = wb_stb | (count != 0). It stays high until the final ack.
- Latency: request to wb_stb is 0 cycles (combinational); ack to rvalid is 0 cycles.
- Ibex holds req until gnt, so locking cannot deadlock.

Optional Feature:
- Macro: IBEX_WB_ARB_ERR_EN.
- Defined: wb_err is treated like ack and drives <head>_err = 1 together with rvalid.
- Undefined: wb_err is ignored entirely (no pop); instr_err = data_err = 0.

Decomposition:
- Package ibex_wb_pkg:
  - typedef enum logic {SRC_INSTR, SRC_DATA} ibex_wb_src_e;
  - localparam InstrSel = 4'hF;
  - localparam MaxOutstandingLimit = 4.
- Sub-module ibex_wb_id_fifo:
  - Parameterised depth FIFO of ibex_wb_src_e.
  - Push/pop/count/head ports; simultaneous push/pop supported.
  - Same clk/rst_n.

Test Plan:
- Single instr read, instr_addr = 0x80, slave acks next cycle with 0x00000013 -> instr_gnt in cycle 0, wb_sel = F, wb_we = 0, instr_rvalid and instr_rdata = 0x13 in cycle 1, wb_cyc drops in cycle 2.
- Both req in the same cycle, DataFirst = 1, data write 0xDEADBEEF to 0x1000 be = 4'b0011 -> data granted first (wb_we = 1, wb_sel = 3), instr granted next; data_rvalid on first ack, instr_rvalid on second.
- wb_stall held 3 cycles with instr strobing, data_req rising during stall -> wb_adr stays instr_addr, no data_gnt until instr accepted.
- MaxOutstanding = 2, three back-to-back instr reqs, acks delayed 4 cycles -> third gnt withheld (wb_stb = 0) until first ack; rvalid order matches issue order.
- DataFirst = 0, both reqs continuously high, 6 accepts -> alternating grants D,I,D,I… starting with DATA after reset (last_q = INSTR).
- rst_n low for 1 cycle with 2 outstanding, then stray ack -> all outputs 0, count = 0, stray ack ignored (no rvalid); with IBEX_WB_ARB_ERR_EN, wb_err on a data read -> data_rvalid = 1 and data_err = 1.

Source files
------------

// File: rtl/ibex_wb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ibex_wb_pkg
// Purpose  : Shared types and constants for the Ibex-to-Wishbone arbiter.
//            ibex_wb_src_e tags every issued transaction with the Ibex
//            port that requested it, so its response can be routed back.
// Revision : 1.0 - initial release
// ============================================================================
package ibex_wb_pkg;

  typedef enum logic {
    SRC_INSTR = 1'b0,
    SRC_DATA  = 1'b1
  } ibex_wb_src_e;

  // Instruction fetches are always full-word reads.
  localparam logic [3:0]  InstrSel            = 4'hF;

  // Upper bound on outstanding transactions. CountWidth must hold 0..limit.
  localparam int unsigned MaxOutstandingLimit = 4;
  localparam int unsigned CountWidth          = 3;

endpackage
`default_nettype wire

// File: rtl/ibex_wb_id_fifo.sv
`default_nettype none
// ============================================================================
// Module   : ibex_wb_id_fifo
// Purpose  : In-order FIFO of source IDs (instruction or data) for the
//            Wishbone transactions that are accepted but not yet acked.
//            The caller never pushes when full or pops when empty.
//            A push and a pop in the same cycle leave the count unchanged.
// Ports    : clk, rst_n       - clock, synchronous active-low reset
//            i_push, i_id     - enqueue i_id
//            i_pop            - dequeue the head entry
//            o_head           - ID of the oldest entry
//            o_count          - number of entries held
// Revision : 1.0 - initial release
// ============================================================================
module ibex_wb_id_fifo
  import ibex_wb_pkg::*;
#(
  parameter int unsigned Depth = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_push,
  input  ibex_wb_src_e          i_id,
  input  logic                  i_pop,
  output ibex_wb_src_e          o_head,
  output logic [CountWidth-1:0] o_count
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

  ibex_wb_src_e          r_mem [Depth];
  logic [PtrW-1:0]       r_wr_ptr;
  logic [PtrW-1:0]       r_rd_ptr;
  logic [CountWidth-1:0] r_count;

  // Wrapping increment; Depth need not be a power of two.
  function automatic logic [PtrW-1:0] f_next(input logic [PtrW-1:0] p);
    if (p == PtrW'(Depth - 1)) begin
      return '0;
    end
    return p + PtrW'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) begin
        r_wr_ptr <= f_next(r_wr_ptr);
      end
      if (i_pop) begin
        r_rd_ptr <= f_next(r_rd_ptr);
      end
      if (i_push && !i_pop) begin
        r_count <= r_count + CountWidth'(1);
      end else if (i_pop && !i_push) begin
        r_count <= r_count - CountWidth'(1);
      end
    end
  end

  // Storage needs no reset; only entries below the count are ever read.
  always_ff @(posedge clk) begin
    if (i_push) begin
      r_mem[r_wr_ptr] <= i_id;
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/ibex_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ibex_wb_arbiter
// Purpose  : Shares one pipelined Wishbone B4 master port between the Ibex
//            instruction and data ports (req/gnt/rvalid). Accepted requests
//            are tagged in an in-order ID FIFO, and each ack is routed back
//            to the port that issued the request.
// Ports    : clk, rst_n               - clock, synchronous active-low reset
//            instr_*                  - Ibex instruction port
//            data_*                   - Ibex data port
//            wb_*                     - Wishbone B4 pipelined master
// Config   : MaxOutstanding (1..4)    - accepted-but-unacked transactions
//            DataFirst                - 1: data wins ties, 0: round-robin
//            IBEX_WB_ARB_ERR_EN       - when defined, wb_err completes a
//                                       transaction and raises *_err;
//                                       otherwise wb_err is ignored
// Revision : 1.0 - initial release
// ============================================================================
module ibex_wb_arbiter
  import ibex_wb_pkg::*;
#(
  parameter int unsigned MaxOutstanding = 2,
  parameter bit          DataFirst      = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        instr_req,
  output logic        instr_gnt,
  output logic        instr_rvalid,
  input  logic [31:0] instr_addr,
  output logic [31:0] instr_rdata,
  output logic        instr_err,
  input  logic        data_req,
  output logic        data_gnt,
  output logic        data_rvalid,
  input  logic        data_we,
  input  logic [3:0]  data_be,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic [31:0] data_rdata,
  output logic        data_err,
  output logic        wb_cyc,
  output logic        wb_stb,
  output logic        wb_we,
  output logic [31:0] wb_adr,
  output logic [3:0]  wb_sel,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack,
  input  logic        wb_stall,
  input  logic        wb_err
);

  // Out-of-range depths are clamped into 1..MaxOutstandingLimit.
  localparam int unsigned Depth =
      (MaxOutstanding > MaxOutstandingLimit) ? MaxOutstandingLimit :
      (MaxOutstanding < 1)                   ? 1 : MaxOutstanding;
  localparam logic [CountWidth-1:0] MaxCount = CountWidth'(Depth);

  ibex_wb_src_e          r_sel_q;
  ibex_wb_src_e          r_last_q;
  logic                  r_lock_q;

  ibex_wb_src_e          w_src;
  ibex_wb_src_e          w_head;
  logic                  w_is_data;
  logic                  w_src_req;
  logic                  w_stb;
  logic                  w_accept;
  logic                  w_resp;
  logic                  w_pop;
  logic [CountWidth-1:0] w_count;

  // A stalled strobe is locked to its source so that the address and
  // strobe stay stable until the slave takes it.
  always_comb begin
    w_src = SRC_INSTR;
    if (r_lock_q) begin
      w_src = r_sel_q;
    end else if (data_req && (!instr_req || DataFirst || (r_last_q == SRC_INSTR))) begin
      w_src = SRC_DATA;
    end
  end

  assign w_is_data = (w_src == SRC_DATA);
  assign w_src_req = w_is_data ? data_req : instr_req;
  assign w_stb     = rst_n & w_src_req & (w_count < MaxCount);
  assign w_accept  = w_stb & ~wb_stall;
  assign w_pop     = rst_n & w_resp & (w_count != '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_lock_q <= 1'b0;
      r_sel_q  <= SRC_INSTR;
      r_last_q <= SRC_INSTR;
    end else if (w_accept) begin
      r_lock_q <= 1'b0;
      r_last_q <= w_src;
    end else if (w_stb) begin
      // Strobe presented but stalled.
      r_lock_q <= 1'b1;
      r_sel_q  <= w_src;
    end
  end

  ibex_wb_id_fifo #(
    .Depth   (Depth)
  ) u_id_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_accept),
    .i_id    (w_src),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_count (w_count)
  );

  // Issue side
  assign instr_gnt = w_accept & ~w_is_data;
  assign data_gnt  = w_accept & w_is_data;
  assign wb_stb    = w_stb;
  assign wb_cyc    = rst_n & (w_stb | (w_count != '0));
  assign wb_we     = rst_n & w_is_data & data_we;
  assign wb_adr    = !rst_n ? '0 : (w_is_data ? data_addr  : instr_addr);
  assign wb_sel    = !rst_n ? '0 : (w_is_data ? data_be    : InstrSel);
  assign wb_dat_o  = !rst_n ? '0 : (w_is_data ? data_wdata : '0);

  // Response side
  assign instr_rvalid = w_pop & (w_head == SRC_INSTR);
  assign data_rvalid  = w_pop & (w_head == SRC_DATA);
  assign instr_rdata  = rst_n ? wb_dat_i : '0;
  assign data_rdata   = rst_n ? wb_dat_i : '0;

`ifdef IBEX_WB_ARB_ERR_EN
  assign w_resp    = wb_ack | wb_err;
  assign instr_err = w_pop & wb_err & (w_head == SRC_INSTR);
  assign data_err  = w_pop & wb_err & (w_head == SRC_DATA);
`else
  logic w_unused_err;
  assign w_unused_err = wb_err;
  assign w_resp       = wb_ack;
  assign instr_err    = 1'b0;
  assign data_err     = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ibex_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_ibex_wb_arbiter
// Purpose  : Self-checking bench for ibex_wb_arbiter. One instance uses
//            fixed data priority, a second uses round-robin. Grants the
//            bench expects are queued as source IDs; every response is
//            matched against the oldest queued ID.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ibex_wb_arbiter;
  import ibex_wb_pkg::*;

`ifdef IBEX_WB_ARB_ERR_EN
  localparam bit ErrEn = 1'b1;
`else
  localparam bit ErrEn = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        instr_req, data_req, data_we;
  logic [31:0] instr_addr, data_addr, data_wdata, wb_dat_i;
  logic [3:0]  data_be;
  logic        wb_ack, wb_stall, wb_err;
  logic        instr_gnt, instr_rvalid, instr_err, data_gnt, data_rvalid, data_err;
  logic [31:0] instr_rdata, data_rdata, wb_adr, wb_dat_o;
  logic        wb_cyc, wb_stb, wb_we;
  logic [3:0]  wb_sel;

  logic        rr_instr_req, rr_data_req, rr_wb_ack;
  logic        rr_instr_gnt, rr_instr_rvalid, rr_instr_err, rr_data_gnt, rr_data_rvalid, rr_data_err;
  logic [31:0] rr_instr_rdata, rr_data_rdata, rr_wb_adr, rr_wb_dat_o;
  logic        rr_wb_cyc, rr_wb_stb, rr_wb_we;
  logic [3:0]  rr_wb_sel;

  ibex_wb_arbiter #(.MaxOutstanding(2), .DataFirst(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .instr_req(instr_req), .instr_gnt(instr_gnt), .instr_rvalid(instr_rvalid),
    .instr_addr(instr_addr), .instr_rdata(instr_rdata), .instr_err(instr_err),
    .data_req(data_req), .data_gnt(data_gnt), .data_rvalid(data_rvalid),
    .data_we(data_we), .data_be(data_be), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_rdata(data_rdata), .data_err(data_err),
    .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we), .wb_adr(wb_adr),
    .wb_sel(wb_sel), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i),
    .wb_ack(wb_ack), .wb_stall(wb_stall), .wb_err(wb_err)
  );

  ibex_wb_arbiter #(.MaxOutstanding(2), .DataFirst(1'b0)) dut_rr (
    .clk(clk), .rst_n(rst_n),
    .instr_req(rr_instr_req), .instr_gnt(rr_instr_gnt), .instr_rvalid(rr_instr_rvalid),
    .instr_addr(instr_addr), .instr_rdata(rr_instr_rdata), .instr_err(rr_instr_err),
    .data_req(rr_data_req), .data_gnt(rr_data_gnt), .data_rvalid(rr_data_rvalid),
    .data_we(data_we), .data_be(data_be), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_rdata(rr_data_rdata), .data_err(rr_data_err),
    .wb_cyc(rr_wb_cyc), .wb_stb(rr_wb_stb), .wb_we(rr_wb_we), .wb_adr(rr_wb_adr),
    .wb_sel(rr_wb_sel), .wb_dat_o(rr_wb_dat_o), .wb_dat_i(wb_dat_i),
    .wb_ack(rr_wb_ack), .wb_stall(wb_stall), .wb_err(wb_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  ibex_wb_src_e sb[$];
  logic e_ig = 1'b0;
  logic e_dg = 1'b0;

  typedef struct {
    logic        ireq, dreq;
    logic [31:0] iadr, dadr;
    logic        dwe;
    logic [3:0]  dbe;
    logic [31:0] dwd;
    logic        stb;
    logic [31:0] adr;
    logic [3:0]  sel;
    logic        we;
    logic [31:0] dat;
    logic        ig, dg;
  } vec_t;
  vec_t vecs[6];

  task automatic chk1(input string name, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Response/grant checker for the main instance, run once per cycle.
  task automatic monitor();
    logic resp, ei, ed, ee;
    ibex_wb_src_e s;
    ei = 1'b0; ed = 1'b0; ee = 1'b0;
    resp = rst_n && (wb_ack || (ErrEn && wb_err));
    if (resp && sb.size() != 0) begin
      s  = sb.pop_front();
      ei = (s == SRC_INSTR);
      ed = (s == SRC_DATA);
      ee = ErrEn && wb_err;
    end
    chk1("instr_rvalid", instr_rvalid, ei);
    chk1("data_rvalid", data_rvalid, ed);
    chk1("instr_err", instr_err, ei && ee);
    chk1("data_err", data_err, ed && ee);
    if (ei) chk32("instr_rdata", instr_rdata, wb_dat_i);
    if (ed) chk32("data_rdata", data_rdata, wb_dat_i);
    chk1("instr_gnt", instr_gnt, e_ig);
    chk1("data_gnt", data_gnt, e_dg);
    if (e_ig) sb.push_back(SRC_INSTR);
    if (e_dg) sb.push_back(SRC_DATA);
    e_ig = 1'b0;
    e_dg = 1'b0;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic tick();
    monitor();
    @(negedge clk);
  endtask

  task automatic chk_all_zero(input string name);
    chk1({name, "_main"}, |{instr_gnt, instr_rvalid, instr_rdata, instr_err,
                            data_gnt, data_rvalid, data_rdata, data_err,
                            wb_cyc, wb_stb, wb_we, wb_adr, wb_sel, wb_dat_o}, 1'b0);
    chk1({name, "_rr"}, |{rr_instr_gnt, rr_instr_rvalid, rr_instr_rdata, rr_instr_err,
                          rr_data_gnt, rr_data_rvalid, rr_data_rdata, rr_data_err,
                          rr_wb_cyc, rr_wb_stb, rr_wb_we, rr_wb_adr, rr_wb_sel, rr_wb_dat_o}, 1'b0);
  endtask

  initial begin
    ibex_wb_src_e exp_g, prev;
    prev = SRC_INSTR;

    vecs[0] = '{1'b0, 1'b0, 32'h80, 32'h1000, 1'b0, 4'h0, 32'h0,
                1'b0, 32'h0, 4'h0, 1'b0, 32'h0, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 32'h80, 32'h1000, 1'b1, 4'h3, 32'hDEADBEEF,
                1'b1, 32'h80, 4'hF, 1'b0, 32'h0, 1'b1, 1'b0};
    vecs[2] = '{1'b0, 1'b1, 32'h80, 32'h1000, 1'b1, 4'h3, 32'hDEADBEEF,
                1'b1, 32'h1000, 4'h3, 1'b1, 32'hDEADBEEF, 1'b0, 1'b1};
    vecs[3] = '{1'b0, 1'b1, 32'h84, 32'h2004, 1'b0, 4'hF, 32'h55,
                1'b1, 32'h2004, 4'hF, 1'b0, 32'h55, 1'b0, 1'b1};
    vecs[4] = '{1'b1, 1'b1, 32'h88, 32'h3000, 1'b1, 4'hC, 32'h12345678,
                1'b1, 32'h3000, 4'hC, 1'b1, 32'h12345678, 1'b0, 1'b1};
    vecs[5] = '{1'b1, 1'b1, 32'h8C, 32'h3004, 1'b0, 4'h1, 32'hCAFE,
                1'b1, 32'h3004, 4'h1, 1'b0, 32'hCAFE, 1'b0, 1'b1};

    // Reset with busy-looking inputs: every output must read zero.
    rst_n = 1'b0;
    instr_req = 1'b1; data_req = 1'b1; rr_instr_req = 1'b1; rr_data_req = 1'b1;
    instr_addr = 32'h44; data_addr = 32'h88; data_we = 1'b1; data_be = 4'hF;
    data_wdata = 32'h1234; wb_dat_i = 32'hFFFF_FFFF;
    wb_ack = 1'b1; rr_wb_ack = 1'b1; wb_stall = 1'b0; wb_err = 1'b0;
    @(negedge clk);
    @(negedge clk);
    settle();
    chk_all_zero("reset_outputs");
    tick();
    rst_n = 1'b1;
    instr_req = 1'b0; data_req = 1'b0; rr_instr_req = 1'b0; rr_data_req = 1'b0;
    wb_ack = 1'b0; rr_wb_ack = 1'b0;
    settle();
    chk1("idle_cyc", wb_cyc, 1'b0);
    tick();

    // Table: one issue cycle from idle, then one ack cycle.
    for (int i = 0; i < 6; i++) begin
      instr_req = vecs[i].ireq; data_req = vecs[i].dreq;
      instr_addr = vecs[i].iadr; data_addr = vecs[i].dadr;
      data_we = vecs[i].dwe; data_be = vecs[i].dbe; data_wdata = vecs[i].dwd;
      e_ig = vecs[i].ig; e_dg = vecs[i].dg;
      settle();
      chk1("vec_stb", wb_stb, vecs[i].stb);
      chk1("vec_cyc", wb_cyc, vecs[i].stb);
      if (vecs[i].stb) begin
        chk32("vec_adr", wb_adr, vecs[i].adr);
        chk32("vec_sel", 32'(wb_sel), 32'(vecs[i].sel));
        chk1("vec_we", wb_we, vecs[i].we);
        chk32("vec_dat_o", wb_dat_o, vecs[i].dat);
      end
      tick();
      instr_req = 1'b0; data_req = 1'b0;
      wb_ack = vecs[i].ig | vecs[i].dg;
      wb_dat_i = 32'hA000_0000 + 32'(i);
      settle();
      chk1("vec_drain_cyc", wb_cyc, vecs[i].ig | vecs[i].dg);
      tick();
      wb_ack = 1'b0;
    end

    // Single instruction read; cyc drops two cycles after issue.
    instr_req = 1'b1; instr_addr = 32'h80; e_ig = 1'b1;
    settle();
    chk32("A_sel", 32'(wb_sel), 32'hF);
    chk1("A_we", wb_we, 1'b0);
    tick();
    instr_req = 1'b0; wb_ack = 1'b1; wb_dat_i = 32'h0000_0013;
    settle();
    chk1("A_cyc_c1", wb_cyc, 1'b1);
    tick();
    wb_ack = 1'b0;
    settle();
    chk1("A_cyc_c2", wb_cyc, 1'b0);
    tick();

    // Simultaneous requests: data write first, then instruction.
    instr_req = 1'b1; instr_addr = 32'h90;
    data_req = 1'b1; data_we = 1'b1; data_addr = 32'h1000; data_be = 4'b0011;
    data_wdata = 32'hDEADBEEF; e_dg = 1'b1;
    settle();
    chk1("B_we", wb_we, 1'b1);
    chk32("B_sel", 32'(wb_sel), 32'h3);
    tick();
    data_req = 1'b0; e_ig = 1'b1;
    settle();
    chk32("B_adr_instr", wb_adr, 32'h90);
    tick();
    instr_req = 1'b0; wb_ack = 1'b1; wb_dat_i = 32'h0000_0B01;
    settle(); tick();
    wb_dat_i = 32'h0000_0B02;
    settle(); tick();
    wb_ack = 1'b0;
    settle(); tick();

    // Stall for 3 cycles: instruction stays locked while data_req rises.
    instr_req = 1'b1; instr_addr = 32'h100; wb_stall = 1'b1;
    data_we = 1'b0; data_addr = 32'h2000; data_be = 4'hF;
    settle();
    chk1("C_stb", wb_stb, 1'b1);
    tick();
    data_req = 1'b1;
    for (int k = 0; k < 2; k++) begin
      settle();
      chk32("C_adr_locked", wb_adr, 32'h100);
      chk32("C_sel_locked", 32'(wb_sel), 32'hF);
      tick();
    end
    wb_stall = 1'b0; e_ig = 1'b1;
    settle();
    chk32("C_adr_accept", wb_adr, 32'h100);
    tick();
    instr_req = 1'b0; e_dg = 1'b1;
    settle();
    chk32("C_adr_data", wb_adr, 32'h2000);
    tick();
    data_req = 1'b0; wb_ack = 1'b1; wb_dat_i = 32'h0000_0C01;
    settle(); tick();
    wb_dat_i = 32'h0000_0C02;
    settle(); tick();
    wb_ack = 1'b0;
    settle(); tick();

    // Outstanding limit: third request waits for the first ack.
    instr_req = 1'b1; instr_addr = 32'h100; e_ig = 1'b1;
    settle(); tick();
    instr_addr = 32'h104; e_ig = 1'b1;
    settle(); tick();
    instr_addr = 32'h108;
    for (int k = 0; k < 2; k++) begin
      settle();
      chk1("D_full_stb", wb_stb, 1'b0);
      chk1("D_full_cyc", wb_cyc, 1'b1);
      tick();
    end
    wb_ack = 1'b1; wb_dat_i = 32'h1111_0100;
    settle();
    chk1("D_ack_full_stb", wb_stb, 1'b0);
    tick();
    wb_dat_i = 32'h1111_0104; e_ig = 1'b1;
    settle();
    chk32("D_adr_third", wb_adr, 32'h108);
    tick();
    instr_req = 1'b0; wb_dat_i = 32'h1111_0108;
    settle(); tick();
    wb_ack = 1'b0;
    settle();
    chk1("D_cyc_done", wb_cyc, 1'b0);
    tick();

    // Round-robin instance: both requests held, grants alternate from DATA.
    rr_instr_req = 1'b1; rr_data_req = 1'b1;
    exp_g = SRC_DATA;
    for (int i = 0; i < 6; i++) begin
      rr_wb_ack = (i > 0);
      settle();
      chk1("E_data_gnt", rr_data_gnt, exp_g == SRC_DATA);
      chk1("E_instr_gnt", rr_instr_gnt, exp_g == SRC_INSTR);
      if (i > 0) begin
        chk1("E_data_rvalid", rr_data_rvalid, prev == SRC_DATA);
        chk1("E_instr_rvalid", rr_instr_rvalid, prev == SRC_INSTR);
      end
      prev  = exp_g;
      exp_g = (exp_g == SRC_DATA) ? SRC_INSTR : SRC_DATA;
      tick();
    end
    rr_instr_req = 1'b0; rr_data_req = 1'b0; rr_wb_ack = 1'b1;
    settle();
    chk1("E_last_rvalid", rr_instr_rvalid, prev == SRC_INSTR);
    tick();
    rr_wb_ack = 1'b0;
    settle();
    chk1("E_cyc_done", rr_wb_cyc, 1'b0);
    tick();

    // Reset with two outstanding, then a stray ack.
    instr_req = 1'b1; instr_addr = 32'h200; e_ig = 1'b1;
    settle(); tick();
    instr_addr = 32'h204; e_ig = 1'b1;
    settle(); tick();
    rst_n = 1'b0; wb_ack = 1'b1; wb_dat_i = 32'h5A5A_5A5A;
    sb.delete();
    settle();
    chk_all_zero("F_reset");
    tick();
    rst_n = 1'b1; instr_req = 1'b0;
    settle();
    chk1("F_stray_cyc", wb_cyc, 1'b0);
    tick();

    // Bus error on a data read.
    wb_ack = 1'b0; data_req = 1'b1; data_we = 1'b0; data_addr = 32'h4000; data_be = 4'hF;
    e_dg = 1'b1;
    settle(); tick();
    data_req = 1'b0; wb_err = 1'b1; wb_dat_i = 32'hBAD0_0000;
    settle();
    chk1("F_err_cyc", wb_cyc, 1'b1);
    tick();
    wb_err = 1'b0; wb_ack = 1'b1; wb_dat_i = 32'h0000_600D;
    settle(); tick();
    wb_ack = 1'b0;
    settle();
    chk1("F_cyc_done", wb_cyc, 1'b0);
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
